// File: rtl/mem_addr_gen_if.sv
// Handshake and address bus between the top-level sequencer and mem_addr_gen.
// The master modport is the sequencer side; the slave modport is the generator side.
interface mem_addr_gen_if #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 32
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic              start;
   logic [2:0]        mode;
   logic              stall;
   logic              abort;
   logic              busy;
   logic              valid;
   logic              done;
   logic [LW-1:0]     lane;
   logic              tsel;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_se;

   modport master (
      output start, mode, stall, abort,
      input  busy, valid, done, lane, tsel, addr_a, addr_se
   );

   modport slave (
      input  start, mode, stall, abort,
      output busy, valid, done, lane, tsel, addr_a, addr_se
   );
endinterface

// File: rtl/mem_addr_gen.sv
// Address sequencer for the matrix-multiply datapath: walks lane/line/group counters
// over one pass and issues A-matrix and S/E addresses each non-stalled cycle.
//
// state  | meaning
// S_IDLE | waiting for start with a legal mode (1..4); outputs zero
// S_RUN  | pass in progress, one address tuple per non-stalled cycle
module mem_addr_gen #(
   parameter int N          = 1344,
   parameter int LANES      = 4,
   parameter int GROUPS     = 2,
   parameter int LINE_BYTES = 64,
   parameter int A_STRIDE   = N * 16,
   parameter int SE_STRIDE  = N * 8,
   parameter int ADDR_W     = 32
) (
   input logic             clk,
   input logic             rst_n,
   mem_addr_gen_if.slave   bus
);
   localparam int LINES  = N / LANES;
   localparam int LW     = (LANES > 1)  ? $clog2(LANES)  : 1;
   localparam int LINE_W = (LINES > 1)  ? $clog2(LINES)  : 1;
   localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   localparam logic [ADDR_W-1:0] P_LB   = ADDR_W'(LINE_BYTES);
   localparam logic [ADDR_W-1:0] P_AS   = ADDR_W'(A_STRIDE);
   localparam logic [ADDR_W-1:0] P_SE   = ADDR_W'(SE_STRIDE);
   localparam logic [ADDR_W-1:0] P_GRP  = ADDR_W'(LANES * SE_STRIDE);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            r_state, w_state_nxt;
   logic [LW-1:0]     r_lane, w_lane_nxt;
   logic [LINE_W-1:0] r_line, w_line_nxt;
   logic [GRP_W-1:0]  r_group, w_group_nxt;
   logic              r_tsel, w_tsel_nxt;
   logic [2:0]        r_mode, w_mode_nxt;
   logic              r_done, w_done_nxt;

   logic w_mode_ok, w_lane_last, w_line_last, w_group_last;

   assign w_mode_ok    = (bus.mode != 3'd0) && (bus.mode <= 3'd4);
   assign w_lane_last  = (r_lane  == LW'(LANES - 1));
   assign w_line_last  = (r_line  == LINE_W'(LINES - 1));
   assign w_group_last = (r_group == GRP_W'(GROUPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_lane  <= '0;
         r_line  <= '0;
         r_group <= '0;
         r_tsel  <= 1'b0;
         r_mode  <= 3'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_lane  <= w_lane_nxt;
         r_line  <= w_line_nxt;
         r_group <= w_group_nxt;
         r_tsel  <= w_tsel_nxt;
         r_mode  <= w_mode_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      w_line_nxt  = r_line;
      w_group_nxt = r_group;
      w_tsel_nxt  = r_tsel;
      w_mode_nxt  = r_mode;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // abort beats a simultaneous start
            if (bus.start && !bus.abort && w_mode_ok) begin
               w_state_nxt = S_RUN;
               w_lane_nxt  = '0;
               w_line_nxt  = '0;
               w_group_nxt = '0;
               w_tsel_nxt  = 1'b0;
               w_mode_nxt  = bus.mode;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               w_state_nxt = S_IDLE;
            end else if (!bus.stall) begin
               w_lane_nxt = r_lane + LW'(1);
               if (w_lane_last) begin
                  w_lane_nxt = '0;
                  w_tsel_nxt = ~r_tsel;
                  w_line_nxt = r_line + LINE_W'(1);
                  if (w_line_last) begin
                     w_line_nxt  = '0;
                     w_group_nxt = r_group + GRP_W'(1);
                     if (w_group_last) begin
                        w_group_nxt = '0;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                     end
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   logic [ADDR_W-1:0] w_line_x, w_lane_x, w_grp_x, w_addr_a, w_addr_se;
   logic              w_transposed, w_valid;

   assign w_valid      = (r_state == S_RUN);
   assign w_line_x     = ADDR_W'(r_line);
   assign w_lane_x     = ADDR_W'(r_lane);
   assign w_grp_x      = ADDR_W'(r_group);
   // SA and BS walk A column-wise: line selects the row, lane the byte offset
   assign w_transposed = (r_mode == 3'd2) || (r_mode == 3'd4);
   assign w_addr_a     = w_transposed ? (w_line_x * P_AS + w_lane_x * P_LB)
                                      : (w_line_x * P_LB + w_lane_x * P_AS);
   assign w_addr_se    = w_line_x * P_LB + w_lane_x * P_SE + w_grp_x * P_GRP;

   assign bus.busy    = w_valid;
   assign bus.valid   = w_valid;
   assign bus.done    = r_done;
   assign bus.tsel    = r_tsel;
   assign bus.lane    = w_valid ? r_lane    : '0;
   assign bus.addr_a  = w_valid ? w_addr_a  : '0;
   assign bus.addr_se = w_valid ? w_addr_se : '0;
endmodule

// File: tb/tb_mem_addr_gen.sv
// Bench for mem_addr_gen at default parameters; expected tuples come from
// decomposing the issued-tuple index into lane/line/group.
module tb_mem_addr_gen;
   localparam int N          = 1344;
   localparam int LANES      = 4;
   localparam int GROUPS     = 2;
   localparam int LINE_BYTES = 64;
   localparam int A_STRIDE   = N * 16;
   localparam int SE_STRIDE  = N * 8;
   localparam int ADDR_W     = 32;
   localparam int LINES      = N / LANES;
   localparam int TOTAL      = GROUPS * N;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   mem_addr_gen_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();

   mem_addr_gen #(
      .N(N), .LANES(LANES), .GROUPS(GROUPS), .LINE_BYTES(LINE_BYTES),
      .A_STRIDE(A_STRIDE), .SE_STRIDE(SE_STRIDE), .ADDR_W(ADDR_W)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_addr_a(int m, int t);
      int ln, li;
      ln = t % LANES;
      li = (t / LANES) % LINES;
      if (m == 2 || m == 4) return 32'(li * A_STRIDE + ln * LINE_BYTES);
      return 32'(li * LINE_BYTES + ln * A_STRIDE);
   endfunction

   function automatic logic [31:0] m_addr_se(int t);
      int ln, li, g;
      ln = t % LANES;
      li = (t / LANES) % LINES;
      g  = t / (LANES * LINES);
      return 32'(li * LINE_BYTES + ln * SE_STRIDE + g * LANES * SE_STRIDE);
   endfunction

   task automatic check_idle(string name, logic exp_done);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.done !== exp_done ||
          bus.lane !== 2'd0 || bus.addr_a !== 32'd0 || bus.addr_se !== 32'd0) begin
         n_err++;
         $display("FAIL %s: busy=%b valid=%b done=%b lane=%0d a=%0d se=%0d, required idle with done=%b",
                  name, bus.busy, bus.valid, bus.done, bus.lane, bus.addr_a, bus.addr_se, exp_done);
      end
   endtask

   // skind: 0 none, 1 random stalls plus ignored start noise, 2 stall during cycles 3..5
   task automatic run_pass(input int m, input int skind, output int stalls, output int done_cyc);
      int  t, cyc;
      bit  st, got_done;
      logic [1:0] el;
      logic       et;
      bus.mode  = 3'(m);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      t = 0; cyc = 1; stalls = 0; got_done = 0; done_cyc = -1;
      for (int i = 0; i < TOTAL + TOTAL / 2 + 16 && !got_done; i++) begin
         if (t < TOTAL) begin
            el = 2'(t % LANES);
            et = 1'((t / LANES) % 2);
            n_vec++;
            if (bus.busy !== 1'b1 || bus.valid !== 1'b1 || bus.done !== 1'b0 ||
                bus.lane !== el || bus.tsel !== et ||
                bus.addr_a !== m_addr_a(m, t) || bus.addr_se !== m_addr_se(t)) begin
               n_err++;
               $display("FAIL tuple m=%0d t=%0d cyc=%0d: busy=%b valid=%b done=%b lane=%0d tsel=%b a=%0d se=%0d, required lane=%0d tsel=%b a=%0d se=%0d",
                        m, t, cyc, bus.busy, bus.valid, bus.done, bus.lane, bus.tsel,
                        bus.addr_a, bus.addr_se, el, et, m_addr_a(m, t), m_addr_se(t));
            end
            st = 0;
            if (skind == 1) begin
               st = ($urandom_range(0, 7) == 0);
               bus.start = ($urandom_range(0, 3) == 0);
               bus.mode  = 3'($urandom_range(0, 7));
            end else if (skind == 2) begin
               st = (cyc >= 3 && cyc <= 5);
            end
            bus.stall = st;
            if (st) stalls++;
            else t++;
            step();
            cyc++;
         end else begin
            bus.start = 1'b0;
            bus.stall = 1'b0;
            check_idle($sformatf("done_cycle m=%0d", m), 1'b1);
            got_done = 1;
            done_cyc = cyc;
         end
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      if (!got_done) begin
         n_vec++;
         n_err++;
         $display("FAIL pass_timeout m=%0d: done not seen, required after %0d tuples", m, TOTAL);
      end
   endtask

   task automatic test_reset();
      check_idle("reset_asserted", 1'b0);
      n_vec++;
      if (bus.tsel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_tsel: tsel=%b required 0", bus.tsel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_idle("reset_released", 1'b0);
   endtask

   task automatic test_as_directed();
      int cyc;
      bus.mode  = 3'd1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (cyc = 1; cyc <= TOTAL + 2; cyc++) begin
         if (cyc == 1 || cyc == 2 || cyc == 5 || cyc == 1345 || cyc == 2688) begin
            logic [31:0] ea, es;
            logic [1:0]  el;
            logic        et;
            case (cyc)
               1:       begin el = 0; et = 0; ea = 0;        es = 0;     end
               2:       begin el = 1; et = 0; ea = 21504;    es = 10752; end
               5:       begin el = 0; et = 1; ea = 64;       es = 64;    end
               1345:    begin el = 0; et = 0; ea = 0;        es = 43008; end
               default: begin el = 3; et = 1; ea = 32'(335 * LINE_BYTES + 3 * A_STRIDE);
                              es = 32'(4 * SE_STRIDE + 335 * LINE_BYTES + 3 * SE_STRIDE); end
            endcase
            n_vec++;
            if (bus.valid !== 1'b1 || bus.lane !== el || bus.tsel !== et ||
                bus.addr_a !== ea || bus.addr_se !== es) begin
               n_err++;
               $display("FAIL as_cycle%0d: valid=%b lane=%0d tsel=%b a=%0d se=%0d, required lane=%0d tsel=%b a=%0d se=%0d",
                        cyc, bus.valid, bus.lane, bus.tsel, bus.addr_a, bus.addr_se, el, et, ea, es);
            end
         end
         if (cyc == TOTAL + 1) check_idle("as_done_pulse", 1'b1);
         if (cyc == TOTAL + 2) check_idle("as_done_cleared", 1'b0);
         if (cyc < TOTAL + 2) step();
      end
   endtask

   task automatic test_stall();
      int stalls, done_cyc;
      run_pass(1, 2, stalls, done_cyc);
      n_vec++;
      if (done_cyc !== 2692) begin
         n_err++;
         $display("FAIL stall_done_cycle: done at cycle %0d, required 2692", done_cyc);
      end
      step();
      check_idle("stall_after_done", 1'b0);
   endtask

   task automatic test_ignored_modes();
      int ml [3] = '{0, 6, 7};
      foreach (ml[i]) begin
         bus.mode  = 3'(ml[i]);
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         check_idle($sformatf("ignored_mode%0d_a", ml[i]), 1'b0);
         step();
         check_idle($sformatf("ignored_mode%0d_b", ml[i]), 1'b0);
      end
      bus.mode  = 3'd1;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_idle("abort_beats_start", 1'b0);
   endtask

   task automatic test_abort();
      bus.mode  = 3'd2;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (cyc == 2 || cyc == 5) begin
            logic [31:0] ea;
            ea = (cyc == 2) ? 32'd64 : 32'd21504;
            n_vec++;
            if (bus.addr_a !== ea || bus.addr_se !== m_addr_se(cyc - 1)) begin
               n_err++;
               $display("FAIL sa_cycle%0d: a=%0d se=%0d, required a=%0d se=%0d",
                        cyc, bus.addr_a, bus.addr_se, ea, m_addr_se(cyc - 1));
            end
         end
         if (cyc == 10) bus.abort = 1'b1;
         step();
      end
      bus.abort = 1'b0;
      check_idle("abort_cycle11", 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_idle("abort_no_done", 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      bus.mode  = 3'd3;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset_mid", 1'b0);
      n_vec++;
      if (bus.tsel !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset_tsel: tsel=%b required 0", bus.tsel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_idle("reset_mid_no_done", 1'b0);
   endtask

   task automatic test_random();
      int stalls, done_cyc;
      for (int m = 1; m <= 4; m++) begin
         run_pass(m, 1, stalls, done_cyc);
         n_vec++;
         if (done_cyc !== TOTAL + 1 + stalls) begin
            n_err++;
            $display("FAIL random_done_cycle m=%0d: done at %0d, required %0d",
                     m, done_cyc, TOTAL + 1 + stalls);
         end
         step();
         check_idle("random_after_done", 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      int stalls, done_cyc;
      run_pass(3, 0, stalls, done_cyc);
      run_pass(4, 0, stalls, done_cyc);
      step();
      check_idle("b2b_after_done", 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.mode  = 3'd0;
      bus.stall = 1'b0;
      bus.abort = 1'b0;
      #12;
      test_reset();
      test_as_directed();
      test_stall();
      test_ignored_modes();
      test_abort();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
